// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared defaults and helpers for the Hack AND primitive.
// Build option: AND_GATE_STATS_EN enables the saturating hit counter.
package and_gate_pkg;

  localparam int AND_WIDTH_DEF = 1;
  localparam int AND_CNT_W_DEF = 16;
  localparam int AND_MAX_W     = 64;

  // AND reduction; callers pad unused high bits with ones
  function automatic logic and_all_ones(
    input logic [AND_MAX_W-1:0] vec
  );
    return &vec;
  endfunction

endpackage

// File: rtl/and_gate_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Synchronous active-high reset.
import and_gate_pkg::*;

module sat_counter #(
  parameter int W = AND_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  // count qualified events, hold at the ceiling
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/and_gate_unit.sv
// and_gate_unit: bitwise AND with registered copy and optional hit stats.
// Build option: AND_GATE_STATS_EN adds hit_cnt and its counter.
import and_gate_pkg::*;

module and_gate_unit #(
  parameter int WIDTH = AND_WIDTH_DEF,
  parameter int CNT_W = AND_CNT_W_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
`ifdef AND_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > AND_MAX_W ||
      CNT_W < 1 || CNT_W > 32) begin : g_bad_cfg
    $error("and_gate_unit: bad WIDTH/CNT_W");
  end

  logic [WIDTH-1:0] res;

  assign res = a & b;
  assign out = res;

  // one-cycle registered copy of the result and its qualifier
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_q     <= res;
      out_valid <= in_valid;
    end
  end

`ifdef AND_GATE_STATS_EN
  logic [AND_MAX_W-1:0] res_ext;
  logic                 hit;

  // pad to the helper width with ones so only real bits matter
  always_comb begin
    res_ext             = '1;
    res_ext[WIDTH-1:0]  = res;
  end

  assign hit = in_valid && and_all_ones(res_ext);

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .cnt (hit_cnt)
  );
`endif

endmodule

// File: tb/tb_and_gate_unit.sv
// tb_and_gate_unit: directed vectors for and_gate_unit.
// Counter checks compile only with AND_GATE_STATS_EN.
module tb_and_gate_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] out1, oq1;
  logic       ov1;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] out8, oq8;
  logic       ov8;
`ifdef AND_GATE_STATS_EN
  logic [15:0] hit1;
  logic [1:0]  hit8;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  and_gate_unit #(.WIDTH(1)) d1 (
    .a(a1), .b(b1), .out(out1),
    .clk(clk), .rst(rst),
    .in_valid(in_valid),
    .out_q(oq1), .out_valid(ov1)
`ifdef AND_GATE_STATS_EN
    , .hit_cnt(hit1)
`endif
  );

  and_gate_unit #(.WIDTH(8), .CNT_W(2)) d8 (
    .a(a8), .b(b8), .out(out8),
    .clk(clk), .rst(rst),
    .in_valid(in_valid),
    .out_q(oq8), .out_valid(ov8)
`ifdef AND_GATE_STATS_EN
    , .hit_cnt(hit8)
`endif
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [0:0] a, b, exp;
  } v1_t;

  typedef struct {
    logic [7:0] a, b, exp;
  } v8_t;

  v1_t tt1[4];
  v8_t tt8[6];

  initial begin
    tt1[0] = '{1'b0, 1'b0, 1'b0};
    tt1[1] = '{1'b0, 1'b1, 1'b0};
    tt1[2] = '{1'b1, 1'b0, 1'b0};
    tt1[3] = '{1'b1, 1'b1, 1'b1};
    tt8[0] = '{8'hF0, 8'h3C, 8'h30};
    tt8[1] = '{8'hFF, 8'hFF, 8'hFF};
    tt8[2] = '{8'h00, 8'hFF, 8'h00};
    tt8[3] = '{8'hAA, 8'h55, 8'h00};
    tt8[4] = '{8'hA5, 8'h0F, 8'h05};
    tt8[5] = '{8'h81, 8'hC3, 8'h81};

    // combinational truth tables, 10 ns per vector
    for (int i = 0; i < 4; i++) begin
      a1 = tt1[i].a;
      b1 = tt1[i].b;
      #10;
      chk($sformatf("tt1[%0d]", i), 64'(out1), 64'(tt1[i].exp));
    end
    for (int i = 0; i < 6; i++) begin
      a8 = tt8[i].a;
      b8 = tt8[i].b;
      #10;
      chk($sformatf("tt8[%0d]", i), 64'(out8), 64'(tt8[i].exp));
    end

    // reset with a qualifying hit on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    edge1();
    chk("rst oq1", 64'(oq1), 64'd0);
    chk("rst ov1", 64'(ov1), 64'd0);
    chk("rst oq8", 64'(oq8), 64'd0);
    chk("rst ov8", 64'(ov8), 64'd0);
    chk("rst out8", 64'(out8), 64'hFF);
`ifdef AND_GATE_STATS_EN
    chk("rst hit8", 64'(hit8), 64'd0);
    chk("rst hit1", 64'(hit1), 64'd0);
`endif

    // registered path: one-cycle latency
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    #1;
    chk("same-cyc out1", 64'(out1), 64'd1);
    chk("pre oq1", 64'(oq1), 64'd0);
    edge1();
    chk("reg oq1", 64'(oq1), 64'd1);
    chk("reg ov1", 64'(ov1), 64'd1);
    chk("reg oq8", 64'(oq8), 64'h30);
`ifdef AND_GATE_STATS_EN
    chk("nohit hit8", 64'(hit8), 64'd0);
    chk("hit1 first", 64'(hit1), 64'd1);
`endif

    // unqualified all-ones: no count, out_q still updates
    @(negedge clk);
    in_valid = 1'b0; a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b0;
    edge1();
    chk("unq oq8", 64'(oq8), 64'hFF);
    chk("unq ov8", 64'(ov8), 64'd0);
    chk("unq oq1", 64'(oq1), 64'd0);
`ifdef AND_GATE_STATS_EN
    chk("unq hit8", 64'(hit8), 64'd0);
`endif

    // saturation with a 2-bit counter: 1,2,3,3,3
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      edge1();
      chk($sformatf("sat ov8 %0d", k), 64'(ov8), 64'd1);
`ifdef AND_GATE_STATS_EN
      chk($sformatf("sat hit8 %0d", k), 64'(hit8),
          64'((k > 3) ? 3 : k));
`endif
    end

    // mid-run reset clears registers, out unaffected
    @(negedge clk);
    rst = 1'b1;
    edge1();
    chk("mid oq8", 64'(oq8), 64'd0);
    chk("mid ov8", 64'(ov8), 64'd0);
    chk("mid out8", 64'(out8), 64'hFF);
`ifdef AND_GATE_STATS_EN
    chk("mid hit8", 64'(hit8), 64'd0);
`endif

    // counting resumes on the first edge after release
    @(negedge clk);
    rst = 1'b0;
    edge1();
    chk("post oq8", 64'(oq8), 64'hFF);
    chk("post ov8", 64'(ov8), 64'd1);
`ifdef AND_GATE_STATS_EN
    chk("post hit8", 64'(hit8), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
